disp_arbiter: RTL and testbench
===============================

# disp_arbiter

Shares the two-digit seven-segment display driver between two requesters, such as a game-state readout and a debug/status readout. It grants the display to one requester at a time, with a guaranteed minimum dwell and round-robin fairness. It drives the driver's `num` value and `idle` blanking input. It sits directly upstream of the display multiplexer in the top level.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000: minimum number of cycles a grant is held (dwell); legal range ≥ 2.
- `CW`, default `$clog2(HOLD_CYCLES)`: dwell counter width (derived; not overridden).

Ports (one clock; reset is asynchronous and active-high):
- `CLK` input 1: system clock; all state on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0` input 1: requester 0 wants the display; level, held while wanted.
- `val0` input 8: requester 0 value; [3:0] is the right digit, [7:4] is the left digit.
- `req1` input 1: requester 1 wants the display.
- `val1` input 8: requester 1 value.
- `gnt0` output 1: requester 0 currently owns the display (registered).
- `gnt1` output 1: requester 1 currently owns the display (registered).
- `num` output 8: value to the display driver (registered).
- `idle` output 1: blank the display; high only when no grant is active (registered).

## Operation
- States: IDLE, OWN0, OWN1. `gnt0` = (state == OWN0), `gnt1` = (state == OWN1), `idle` = (state == IDLE). `gnt0` and `gnt1` are never both high.
- `last` (1 bit) records the most recently granted requester. Reset value is 1, so requester 0 wins the first tie.
- IDLE:
  - With only one request high, that requester is granted.
  - With both high, the requester ≠ `last` is granted.
  - With none high, stay in IDLE.
  - On grant: `num` ← `valX` of the granted requester, dwell counter ← 0, `last` ← X.
- OWNx, counter running:
  - While `reqX` is high, `num` ← `valX` every cycle (live tracking).
  - While `reqX` is low, `num` holds its last captured value.
  - The counter increments each cycle and saturates at `HOLD_CYCLES-1`.
- Dwell expired (counter == `HOLD_CYCLES-1`), evaluated every cycle:
  - Other requester high: switch directly to OWN(other). `num` ← `val(other)`, counter ← 0, `last` ← other. No IDLE gap, and no cycle where neither grant is high.
  - Else, `reqX` high: stay in OWNx, counter stays saturated, tracking continues.
  - Else: go to IDLE. `num` holds its value, `idle` rises.
- Dropping `reqX` before the dwell expires does not release the grant early. The display keeps the frozen value until expiry.
- The counter is `CW` bits. Compare equality against `HOLD_CYCLES-1`; the counter never wraps.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `gnt0`=0, `gnt1`=0, `idle`=1, `num`=8'h00, counter 0, `last`=1.
- Grant latency: a request sampled high in IDLE at edge N gives `gnt`/`num` valid after edge N, i.e. 1 cycle.
- Value tracking latency while granted: `valX` change at edge N appears on `num` after edge N.
- Minimum ownership: `HOLD_CYCLES` cycles from the grant edge to the earliest switch/release edge.
- Simultaneous events:
  - Both requests rise in the same cycle in IDLE: round-robin decision by `last`.
  - `reqX` falls in the same cycle the other request rises, at expiry: switch, not IDLE.
- Reset asserted mid-grant: immediate return to the reset values. After reset release, the first edge re-arbitrates with `last`=1.

## Structure
- Shared package `disp_pkg`:
  - `disp_state_t` enum {IDLE, OWN0, OWN1}.
  - `DISP_BLANK` = 8'h00 (the reset value of `num`).
- One sub-module: `dwell_timer`.
  - Parameters: `HOLD_CYCLES`.
  - Ports: `CLK`, `rst`, `clear`, `expired`.
  - Behaviour: saturating counter; `expired` is high when count == `HOLD_CYCLES-1`.
- `disp_arbiter` holds the FSM, the `last` pointer and the `num` register.

## Test plan
All scenarios use `HOLD_CYCLES`=4.

- Reset: assert `rst` mid-OWN0 → same cycle `gnt0`=0, `gnt1`=0, `idle`=1, `num`=8'h00. Release, then `req0`=1 with `val0`=8'h42 → one cycle later `gnt0`=1, `num`=8'h42, `idle`=0.
- Single owner tracking: OWN1 with `val1` stepping 8'h10 → 8'h11 → 8'h12 on consecutive edges → `num` follows with 1-cycle lag; `gnt1` stays high while `req1` is held.
- Tie and round-robin: from reset, `req0`=1 and `req1`=1 in the same cycle → OWN0 first. Keep both high → `gnt1` rises exactly 4 cycles after the `gnt0` grant edge, with no idle cycle. Four cycles later, back to OWN0.
- Early release: `req0` drops 1 cycle after grant while `val0` was 8'h37 → `num` stays 8'h37 and `gnt0` stays high until the 4-cycle dwell expires, then `idle`=1 and `num` still 8'h37.
- Preempt at expiry: OWN0 with `req0` held; `req1` rises at cycle 2 → the switch happens on the expiry edge (cycle 4), not earlier; `num` ← `val1` on that edge.
- Idle re-grant: `req1` drops in OWN1 after expiry → next edge is IDLE. `req0` then rises → OWN0, `num` = `val0`, `idle` falls after 1 cycle.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display arbiter slice.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } disp_state_t;

  localparam logic [7:0] DISP_BLANK = 8'h00;

endpackage

// File: rtl/dwell_timer.sv
// Saturating dwell counter; expired stays high once the count reaches HOLD_CYCLES-1.
module dwell_timer
  import disp_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CW          = $clog2(HOLD_CYCLES)
) (
  input  logic CLK,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam logic [CW-1:0] CntMax = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (cnt_q != CntMax) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (cnt_q == CntMax);

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing the seven-segment driver between two requesters,
// holding each grant for at least HOLD_CYCLES cycles.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CW          = $clog2(HOLD_CYCLES)
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] val0,
  input  logic       req1,
  input  logic [7:0] val1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] num,
  output logic       idle
);

  disp_state_t state_q, state_d;
  logic [7:0]  num_q, num_d;
  logic        last_q, last_d;
  logic        clear;
  logic        expired;

  dwell_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CW          (CW)
  ) u_dwell_timer (
    .CLK     (CLK),
    .rst     (rst),
    .clear   (clear),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    last_d  = last_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        clear = 1'b1;
        // On a tie the requester that was not granted last wins.
        if (req0 && (!req1 || last_q)) begin
          state_d = OWN0;
          num_d   = val0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = OWN1;
          num_d   = val1;
          last_d  = 1'b1;
        end
      end
      OWN0: begin
        if (expired && req1) begin
          state_d = OWN1;
          num_d   = val1;
          last_d  = 1'b1;
          clear   = 1'b1;
        end else if (req0) begin
          num_d = val0;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        if (expired && req0) begin
          state_d = OWN0;
          num_d   = val0;
          last_d  = 1'b0;
          clear   = 1'b1;
        end else if (req1) begin
          num_d = val1;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= DISP_BLANK;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      last_q  <= last_d;
    end
  end

  assign gnt0 = (state_q == OWN0);
  assign gnt1 = (state_q == OWN1);
  assign idle = (state_q == IDLE);
  assign num  = num_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard bench for disp_arbiter with HOLD_CYCLES=4 and directed vectors.
module tb_disp_arbiter;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic [7:0] val0 = 8'h00;
  logic       req1 = 1'b0;
  logic [7:0] val1 = 8'h00;
  logic       gnt0, gnt1, idle;
  logic [7:0] num;

  disp_arbiter #(
    .HOLD_CYCLES (4)
  ) dut (
    .CLK  (CLK),
    .rst  (rst),
    .req0 (req0),
    .val0 (val0),
    .req1 (req1),
    .val1 (val1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .num  (num),
    .idle (idle)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         id;
    logic       g0;
    logic       g1;
    logic       idl;
    logic [7:0] nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;

  task automatic check(input int id, input logic eg0, input logic eg1, input logic eidl,
                       input logic [7:0] en);
    n_checks++;
    if ({gnt0, gnt1, idle, num} === {eg0, eg1, eidl, en}) begin
      n_pass++;
    end else begin
      $display("FAIL step%0d: got gnt0=%b gnt1=%b idle=%b num=%h, want gnt0=%b gnt1=%b idle=%b num=%h",
               id, gnt0, gnt1, idle, num, eg0, eg1, eidl, en);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next
  // rising edge. Reset is asynchronous, so it is also checked immediately.
  task automatic step(input logic r, input logic a0, input logic [7:0] v0, input logic a1,
                      input logic [7:0] v1, input logic eg0, input logic eg1, input logic eidl,
                      input logic [7:0] en);
    exp_t e;
    @(negedge CLK);
    rst  = r;
    req0 = a0;
    val0 = v0;
    req1 = a1;
    val1 = v1;
    if (r) begin
      #1;
      check(step_id, eg0, eg1, eidl, en);
    end
    e.id  = step_id;
    e.g0  = eg0;
    e.g1  = eg1;
    e.idl = eidl;
    e.nm  = en;
    exp_q.push_back(e);
    step_id++;
  endtask

  // Monitor: compare every cycle the scoreboard holds an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.id, e.g0, e.g1, e.idl, e.nm);
      end
    end
  end

  initial begin
    #1;
    check(-1, 1'b0, 1'b0, 1'b1, 8'h00);

    // Tie from reset: OWN0 first, then alternate every 4 cycles with no idle gap.
    for (int i = 0; i < 4; i++) step(0, 1, 8'hA1, 1, 8'hB1, 1, 0, 0, 8'hA1);
    for (int i = 0; i < 4; i++) step(0, 1, 8'hA1, 1, 8'hB1, 0, 1, 0, 8'hB1);
    step(0, 1, 8'hA1, 1, 8'hB1, 1, 0, 0, 8'hA1);
    for (int i = 0; i < 3; i++) step(0, 0, 8'hA1, 0, 8'hB1, 1, 0, 0, 8'hA1);
    step(0, 0, 8'hA1, 0, 8'hB1, 0, 0, 1, 8'hA1);

    // Early release: value frozen until dwell expiry, then idle with value kept.
    step(0, 1, 8'h37, 0, 8'h00, 1, 0, 0, 8'h37);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h99, 0, 8'h00, 1, 0, 0, 8'h37);
    step(0, 0, 8'h99, 0, 8'h00, 0, 0, 1, 8'h37);
    step(0, 0, 8'h99, 0, 8'h00, 0, 0, 1, 8'h37);

    // Single owner tracking, saturation, then release to idle.
    step(0, 0, 8'h00, 1, 8'h10, 0, 1, 0, 8'h10);
    step(0, 0, 8'h00, 1, 8'h11, 0, 1, 0, 8'h11);
    step(0, 0, 8'h00, 1, 8'h12, 0, 1, 0, 8'h12);
    step(0, 0, 8'h00, 1, 8'h12, 0, 1, 0, 8'h12);
    step(0, 0, 8'h00, 1, 8'h13, 0, 1, 0, 8'h13);
    step(0, 0, 8'h00, 0, 8'h13, 0, 0, 1, 8'h13);

    // Idle re-grant.
    step(0, 1, 8'h55, 0, 8'h00, 1, 0, 0, 8'h55);

    // Preempt only at expiry; req0 falls in the same cycle req1 is seen at expiry.
    step(0, 1, 8'h56, 0, 8'h00, 1, 0, 0, 8'h56);
    step(0, 1, 8'h57, 1, 8'h77, 1, 0, 0, 8'h57);
    step(0, 1, 8'h57, 1, 8'h77, 1, 0, 0, 8'h57);
    step(0, 0, 8'h58, 1, 8'h77, 0, 1, 0, 8'h77);

    // Owner drops immediately; value held; req0 takes over at expiry.
    for (int i = 0; i < 3; i++) step(0, 1, 8'h60, 0, 8'h00, 0, 1, 0, 8'h77);
    step(0, 1, 8'h60, 0, 8'h00, 1, 0, 0, 8'h60);
    step(0, 1, 8'h61, 0, 8'h00, 1, 0, 0, 8'h61);

    // Reset mid-OWN0, then re-grant after release.
    step(1, 1, 8'h42, 0, 8'h00, 0, 0, 1, 8'h00);
    step(0, 1, 8'h42, 0, 8'h00, 1, 0, 0, 8'h42);

    // Tie right after reset goes to requester 0 again.
    for (int i = 0; i < 3; i++) step(0, 1, 8'h43, 1, 8'hC0, 1, 0, 0, 8'h43);
    step(0, 1, 8'h43, 1, 8'hC0, 0, 1, 0, 8'hC0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
